// File: rtl/toe_cam_pkg.sv
// Shared definitions for the TOE CAM way allocator.
//   NUM_WAYS  : ways per hashed bucket
//   WAY_W     : width of a way index
//   OP_*      : request opcodes
//   alloc_state_e : allocator FSM encoding
package toe_cam_pkg;

   localparam int NUM_WAYS = 3;
   localparam int WAY_W    = 2;

   localparam logic OP_INSERT = 1'b0;
   localparam logic OP_DELETE = 1'b1;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_RESP = 2'd2
   } alloc_state_e;

endpackage

// File: rtl/toe_cam_occ_table.sv
// Per-bucket occupancy table: 2^B entries x NUM_WAYS bits.
// One synchronous write port, one asynchronous read port. No reset; the
// allocator clears every entry with its INIT sweep.
//   clk_i      : clock
//   wr_en_i    : write enable
//   wr_addr_i  : bucket written
//   wr_data_i  : new occupancy bits
//   rd_addr_i  : bucket read
//   rd_data_o  : occupancy bits of rd_addr_i (combinational)
module toe_cam_occ_table
   import toe_cam_pkg::*;
#(
   parameter int B = 6
) (
   input  logic                clk_i,
   input  logic                wr_en_i,
   input  logic [B-1:0]        wr_addr_i,
   input  logic [NUM_WAYS-1:0] wr_data_i,
   input  logic [B-1:0]        rd_addr_i,
   output logic [NUM_WAYS-1:0] rd_data_o
);

   logic [NUM_WAYS-1:0] mem_q [2**B];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/toe_cam_way_alloc.sv
// Way allocator for a hashed 3-way CAM bucket.
// Inserts take the lowest free way, or a random victim when the bucket is
// full; deletes release a way. One request in flight; response one cycle
// after accept, held until Rsp_Ready.
//   Clk, Rst              : clock, synchronous active-high reset
//   Rnd_Mod               : registered random way 0..2 (3 folds to 0)
//   Req_Valid/Req_Ready   : request handshake
//   Req_Op                : OP_INSERT / OP_DELETE
//   Req_Bucket, Req_Way   : bucket index, way to free (delete only)
//   Rsp_Valid/Rsp_Ready   : response handshake
//   Rsp_Way, Rsp_Evict    : chosen/freed way, insert overwrote a live way
//   Rsp_Err               : delete of a free way or of way 3
//   Init_Done             : occupancy table has been cleared
//
// state | meaning
// INIT  | sweep clears one bucket per cycle, requests blocked
// IDLE  | ready; decide and update table in the accept cycle
// RESP  | response valid, waiting for Rsp_Ready
module toe_cam_way_alloc
   import toe_cam_pkg::*;
#(
   parameter int B = 6,
   parameter int W = 2
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic [W-1:0] Rnd_Mod,
   input  logic         Req_Valid,
   output logic         Req_Ready,
   input  logic         Req_Op,
   input  logic [B-1:0] Req_Bucket,
   input  logic [W-1:0] Req_Way,
   output logic         Rsp_Valid,
   input  logic         Rsp_Ready,
   output logic [W-1:0] Rsp_Way,
   output logic         Rsp_Evict,
   output logic         Rsp_Err,
   output logic         Init_Done
);

   alloc_state_e        state_q, state_d;
   logic [B-1:0]        cnt_q, cnt_d;
   logic                init_done_q, init_done_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [W-1:0]        rsp_way_q, rsp_way_d;
   logic                rsp_evict_q, rsp_evict_d;
   logic                rsp_err_q, rsp_err_d;

   logic                wr_en;
   logic [B-1:0]        wr_addr;
   logic [NUM_WAYS-1:0] wr_data;
   logic [NUM_WAYS-1:0] occ;

   logic [W-1:0]        free_way;
   logic [NUM_WAYS-1:0] free_mask;
   logic [NUM_WAYS-1:0] del_mask;
   logic [W-1:0]        rnd_way;
   logic                occ_full;
   logic                del_hit;

   toe_cam_occ_table #(.B(B)) u_occ_table (
      .clk_i     (Clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (Req_Bucket),
      .rd_data_o (occ)
   );

   // First-free priority encoder, lowest index wins.
   always_comb begin
      free_way  = W'(2);
      free_mask = 3'b100;
      if (!occ[0]) begin
         free_way  = W'(0);
         free_mask = 3'b001;
      end else if (!occ[1]) begin
         free_way  = W'(1);
         free_mask = 3'b010;
      end
   end

   // Way 3 selects nothing, so a delete of way 3 can never hit.
   always_comb begin
      case (Req_Way)
         W'(0):   del_mask = 3'b001;
         W'(1):   del_mask = 3'b010;
         W'(2):   del_mask = 3'b100;
         default: del_mask = 3'b000;
      endcase
   end

   assign occ_full = &occ;
   assign del_hit  = |(occ & del_mask);
   assign rnd_way  = (Rnd_Mod == W'(3)) ? W'(0) : Rnd_Mod;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      rsp_valid_d = rsp_valid_q;
      rsp_way_d   = rsp_way_q;
      rsp_evict_d = rsp_evict_q;
      rsp_err_d   = rsp_err_q;
      wr_en       = 1'b0;
      wr_addr     = Req_Bucket;
      wr_data     = occ;
      Req_Ready   = 1'b0;

      case (state_q)
         ST_INIT: begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
            cnt_d   = cnt_q + B'(1);
            if (cnt_q == '1) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end
         end
         ST_IDLE: begin
            Req_Ready = 1'b1;
            if (Req_Valid) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_evict_d = 1'b0;
               rsp_err_d   = 1'b0;
               if (Req_Op == OP_INSERT) begin
                  if (occ_full) begin
                     rsp_way_d   = rnd_way;
                     rsp_evict_d = 1'b1;
                  end else begin
                     rsp_way_d = free_way;
                     wr_en     = 1'b1;
                     wr_data   = occ | free_mask;
                  end
               end else begin
                  rsp_way_d = Req_Way;
                  if (del_hit) begin
                     wr_en   = 1'b1;
                     wr_data = occ & ~del_mask;
                  end else begin
                     rsp_err_d = 1'b1;
                  end
               end
            end
         end
         ST_RESP: begin
            if (Rsp_Ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_way_q   <= '0;
         rsp_evict_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_way_q   <= rsp_way_d;
         rsp_evict_q <= rsp_evict_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign Rsp_Valid = rsp_valid_q;
   assign Rsp_Way   = rsp_way_q;
   assign Rsp_Evict = rsp_evict_q;
   assign Rsp_Err   = rsp_err_q;
   assign Init_Done = init_done_q;

endmodule
